control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_pkg.sv | 96 +++++++++
 rtl/control_decode.sv | 91 +++++++++
 rtl/control_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the accumulator-machine controller.
// Holds the opcode map, FSM state encoding, ALU operation codes, datapath
// select encodings, the bundled control word and small opcode classifiers.
package control_pkg;

    typedef enum logic [3:0] {
        OP_HALT  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JUMP  = 4'h8,
        OP_SKIPZ = 4'h9,
        OP_SKIPN = 4'hA,
        OP_CLEAR = 4'hB,
        OP_SHL   = 4'hC,
        OP_SHR   = 4'hD,
        OP_ILL_E = 4'hE,
        OP_ILL_F = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_W,
        FETCH_I,
        DECODE,
        EX_A,
        EX_W,
        EX_M,
        EX_C,
        EX_S,
        HALTED
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;

    localparam logic       PC_SEL_INC   = 1'b0;
    localparam logic       PC_SEL_IR    = 1'b1;
    localparam logic       MAR_SEL_PC   = 1'b0;
    localparam logic       MAR_SEL_IR   = 1'b1;
    localparam logic       MBR_SEL_MEM  = 1'b0;
    localparam logic       MBR_SEL_ACC  = 1'b1;
    localparam logic [1:0] ACC_SEL_ALU  = 2'b00;
    localparam logic [1:0] ACC_SEL_MBR  = 2'b01;
    localparam logic [1:0] ACC_SEL_ZERO = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic       mar_we;
        logic       mbr_we;
        logic       ir_we;
        logic       acc_we;
        logic       mem_we;
        logic       pc_sel;
        logic       mar_sel;
        logic       mbr_sel;
        logic [1:0] acc_sel;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    // Opcodes that complete in DECODE.
    function automatic logic is_single(opcode_t op);
        return op inside {OP_HALT, OP_JUMP, OP_SKIPZ, OP_SKIPN, OP_CLEAR,
                          OP_SHL, OP_SHR, OP_ILL_E, OP_ILL_F};
    endfunction

    // Opcodes that stop the machine.
    function automatic logic is_stop(opcode_t op);
        return op inside {OP_HALT, OP_ILL_E, OP_ILL_F};
    endfunction

    function automatic logic [3:0] alu_code(opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control decode.
// Turns the registered FSM state plus the IR opcode and ACC contents into the
// full datapath control word.  IR/ACC only influence the word in DECODE,
// EX_A and EX_C; every other state produces a fixed Moore pattern.
//   state  : current FSM state
//   opcode : IR[15:12]
//   acc_q  : accumulator, used by SKIPZ/SKIPN
//   ctrl   : strobes, selects, alu_op, instr_done, halted
import control_pkg::*;

module control_decode (
    input  state_t      state,
    input  logic [3:0]  opcode,
    input  logic [15:0] acc_q,
    output ctrl_t       ctrl
);

    opcode_t op;

    always_comb begin
        op   = opcode_t'(opcode);
        ctrl = '0;
        case (state)
            FETCH_A: begin
                ctrl.mar_we  = 1'b1;
                ctrl.mar_sel = MAR_SEL_PC;
            end
            FETCH_I: begin
                ctrl.ir_we  = 1'b1;
                ctrl.pc_we  = 1'b1;
                ctrl.pc_sel = PC_SEL_INC;
            end
            DECODE: begin
                ctrl.instr_done = is_single(op);
                case (op)
                    OP_JUMP: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PC_SEL_IR;
                    end
                    OP_SKIPZ: begin
                        ctrl.pc_we  = (acc_q == '0);
                        ctrl.pc_sel = PC_SEL_INC;
                    end
                    OP_SKIPN: begin
                        ctrl.pc_we  = acc_q[15];
                        ctrl.pc_sel = PC_SEL_INC;
                    end
                    OP_CLEAR: begin
                        ctrl.acc_we  = 1'b1;
                        ctrl.acc_sel = ACC_SEL_ZERO;
                    end
                    OP_SHL, OP_SHR: begin
                        ctrl.acc_we  = 1'b1;
                        ctrl.acc_sel = ACC_SEL_ALU;
                        ctrl.alu_op  = alu_code(op);
                    end
                    default: ;
                endcase
            end
            EX_A: begin
                ctrl.mar_we  = 1'b1;
                ctrl.mar_sel = MAR_SEL_IR;
                if (op == OP_STORE) begin
                    ctrl.mbr_we  = 1'b1;
                    ctrl.mbr_sel = MBR_SEL_ACC;
                end
            end
            EX_M: begin
                ctrl.mbr_we  = 1'b1;
                ctrl.mbr_sel = MBR_SEL_MEM;
            end
            EX_C: begin
                ctrl.acc_we     = 1'b1;
                ctrl.instr_done = 1'b1;
                if (op == OP_LOAD) begin
                    ctrl.acc_sel = ACC_SEL_MBR;
                end else begin
                    ctrl.acc_sel = ACC_SEL_ALU;
                    ctrl.alu_op  = alu_code(op);
                end
            end
            EX_S: begin
                ctrl.mem_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            HALTED: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller for a 16-bit accumulator machine.
// Sequences fetch (address, memory wait, IR load), decode and the memory
// execute paths; the memory wait lengths come from MEM_LAT via a down-counter.
//   clk, reset (sync, active high), run (level enable)
//   ir_q, acc_q            : IR and ACC contents from the datapath
//   *_we                   : register / memory write strobes (0 while reset)
//   pc_sel, mar_sel, mbr_sel, acc_sel, alu_op : datapath steering
//   instr_done, halted, illegal : status
import control_pkg::*;

module control_unit #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir_q,
    input  logic [15:0] acc_q,
    output logic        pc_we,
    output logic        mar_we,
    output logic        mbr_we,
    output logic        ir_we,
    output logic        acc_we,
    output logic        mem_we,
    output logic        pc_sel,
    output logic        mar_sel,
    output logic        mbr_sel,
    output logic [1:0]  acc_sel,
    output logic [3:0]  alu_op,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] wait_cnt;
    logic       illegal_q;
    opcode_t    op;
    ctrl_t      ctrl;

    // The operand address is consumed by the datapath, not the controller.
    logic unused_addr;
    assign unused_addr = ^ir_q[ADDR_W-1:0];

    assign op = opcode_t'(ir_q[15:12]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Reload on the cycle before each wait state so the wait lasts
            // exactly MEM_LAT cycles.
            if (state == FETCH_A || state == EX_A) begin
                wait_cnt <= WAIT_INIT;
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == DECODE && (op == OP_ILL_E || op == OP_ILL_F)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH_A;
            FETCH_A: state_nxt = FETCH_W;
            FETCH_W: if (wait_cnt == '0) state_nxt = FETCH_I;
            FETCH_I: state_nxt = DECODE;
            DECODE: begin
                if (is_stop(op)) begin
                    state_nxt = HALTED;
                end else if (is_single(op)) begin
                    state_nxt = run ? FETCH_A : IDLE;
                end else begin
                    state_nxt = EX_A;
                end
            end
            // STORE captures ACC into MBR alongside the address in EX_A,
            // so it needs no memory wait before writing in EX_S.
            EX_A:    state_nxt = (op == OP_STORE) ? EX_S : EX_W;
            EX_W:    if (wait_cnt == '0) state_nxt = EX_M;
            EX_M:    state_nxt = EX_C;
            EX_C,
            EX_S:    state_nxt = run ? FETCH_A : IDLE;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    control_decode u_decode (
        .state  (state),
        .opcode (ir_q[15:12]),
        .acc_q  (acc_q),
        .ctrl   (ctrl)
    );

    // Strobes are masked by reset itself so a reset cycle never writes.
    assign pc_we      = ctrl.pc_we  & ~reset;
    assign mar_we     = ctrl.mar_we & ~reset;
    assign mbr_we     = ctrl.mbr_we & ~reset;
    assign ir_we      = ctrl.ir_we  & ~reset;
    assign acc_we     = ctrl.acc_we & ~reset;
    assign mem_we     = ctrl.mem_we & ~reset;
    assign pc_sel     = ctrl.pc_sel;
    assign mar_sel    = ctrl.mar_sel;
    assign mbr_sel    = ctrl.mbr_sel;
    assign acc_sel    = ctrl.acc_sel;
    assign alu_op     = ctrl.alu_op;
    assign instr_done = ctrl.instr_done;
    assign halted     = ctrl.halted;
    assign illegal    = illegal_q;

endmodule
